// File: rtl/reg_bus_pkg.sv
// Shared register-bus definitions: region geometry, FSM states and payload types.
// Reused by the rate decoupler, the address decoder and the peripherals.
package reg_bus_pkg;

    localparam int unsigned REG_NREGION = 4;
    localparam int unsigned REG_SEL_W   = 2;
    localparam int unsigned REG_DW      = 32;
    localparam int unsigned REG_CNT_W   = 16;

    localparam logic [REG_DW-1:0] REG_TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } reg_state_e;

    // Operation latched at acceptance; held for the life of the transaction
    typedef struct packed {
        logic                 wr;
        logic [REG_SEL_W-1:0] sel;
    } reg_op_t;

    function automatic logic [REG_DW-1:0] reg_rdata_slice(
        input logic [REG_NREGION*REG_DW-1:0] bus,
        input logic [REG_SEL_W-1:0]          idx
    );
        return bus[32'(idx)*REG_DW +: REG_DW];
    endfunction

    function automatic logic [REG_NREGION-1:0] reg_onehot(
        input logic [REG_SEL_W-1:0] idx
    );
        return REG_NREGION'(1) << idx;
    endfunction

endpackage

// File: rtl/reg_to_wdog.sv
// Transaction timeout counter and saturating timeout-event counter.
// expire_c fires combinationally in the last allowed cycle when no ready is seen.
module reg_to_wdog
    import reg_bus_pkg::*;
#(
    parameter int unsigned TO_CYC = 255
) (
    input  logic                 clk_2,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 run,
    input  logic                 hit,
    output logic                 expire_c,
    output logic [REG_CNT_W-1:0] err_cnt
);

    localparam logic [REG_CNT_W-1:0] CNT_LAST = REG_CNT_W'(TO_CYC - 1);
    localparam logic [REG_CNT_W-1:0] CNT_MAX  = {REG_CNT_W{1'b1}};

    logic [REG_CNT_W-1:0] cnt_q, cnt_d;
    logic [REG_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        expire_c  = run && !hit && (cnt_q == CNT_LAST);

        if (start) begin
            cnt_d = '0;
        end else if (run && !hit && !expire_c) begin
            cnt_d = cnt_q + REG_CNT_W'(1);
        end

        if (expire_c && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + REG_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_2) begin
        if (rst) begin
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

endmodule

// File: rtl/reg_addr_dec.sv
// Slow-domain register-bus address decoder: routes each request to one of four
// regions, muxes the response back, and forces completion if a region never answers.
module reg_addr_dec
    import reg_bus_pkg::*;
#(
    parameter int unsigned AW     = 10,
    parameter int unsigned TO_CYC = 255
) (
    input  logic                          clk_2,
    input  logic                          rst,
    input  logic [AW-1:0]                 s_addr,
    input  logic                          s_rd,
    input  logic                          s_wr,
    input  logic [REG_DW-1:0]             s_writedata,
    output logic                          s_ready,
    output logic [REG_DW-1:0]             s_readdata,
    output logic [AW-3:0]                 m_addr,
    output logic [REG_NREGION-1:0]        m_rd,
    output logic [REG_NREGION-1:0]        m_wr,
    output logic [REG_DW-1:0]             m_writedata,
    input  logic [REG_NREGION-1:0]        m_ready,
    input  logic [REG_NREGION*REG_DW-1:0] m_readdata,
    output logic                          timeout_err,
    output logic [REG_CNT_W-1:0]          err_cnt
);

    localparam int unsigned PAW = AW - REG_SEL_W;

    reg_state_e               state_q, state_d;
    reg_op_t                  op_q, op_d;
    logic [PAW-1:0]           m_addr_q, m_addr_d;
    logic [REG_DW-1:0]        m_writedata_q, m_writedata_d;
    logic [REG_NREGION-1:0]   m_rd_q, m_rd_d;
    logic [REG_NREGION-1:0]   m_wr_q, m_wr_d;
    logic                     s_ready_q, s_ready_d;
    logic [REG_DW-1:0]        s_readdata_q, s_readdata_d;
    logic                     timeout_err_q, timeout_err_d;

    logic                     wd_start_c;
    logic                     wd_run_c;
    logic                     sel_ready_c;
    logic                     expire_c;
    logic [REG_SEL_W-1:0]     req_sel_c;

    // Only the latched region's ready counts; the others are ignored entirely
    assign sel_ready_c = m_ready[op_q.sel];
    assign req_sel_c   = s_addr[AW-1 -: REG_SEL_W];

    reg_to_wdog #(
        .TO_CYC (TO_CYC)
    ) u_wdog (
        .clk_2    (clk_2),
        .rst      (rst),
        .start    (wd_start_c),
        .run      (wd_run_c),
        .hit      (sel_ready_c),
        .expire_c (expire_c),
        .err_cnt  (err_cnt)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        m_addr_d      = m_addr_q;
        m_writedata_d = m_writedata_q;
        m_rd_d        = m_rd_q;
        m_wr_d        = m_wr_q;
        s_ready_d     = 1'b0;
        s_readdata_d  = s_readdata_q;
        timeout_err_d = 1'b0;
        wd_start_c    = 1'b0;
        wd_run_c      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (s_rd || s_wr) begin
                    op_d.wr       = s_wr;
                    op_d.sel      = req_sel_c;
                    m_addr_d      = s_addr[PAW-1:0];
                    m_writedata_d = s_writedata;
                    m_rd_d        = s_wr ? '0 : reg_onehot(req_sel_c);
                    m_wr_d        = s_wr ? reg_onehot(req_sel_c) : '0;
                    wd_start_c    = 1'b1;
                    state_d       = REQ;
                end
            end

            REQ: begin
                wd_run_c = 1'b1;
                if (sel_ready_c) begin
                    m_rd_d    = '0;
                    m_wr_d    = '0;
                    s_ready_d = 1'b1;
                    if (!op_q.wr) begin
                        s_readdata_d = reg_rdata_slice(m_readdata, op_q.sel);
                    end
                    state_d = DONE;
                end else if (expire_c) begin
                    m_rd_d        = '0;
                    m_wr_d        = '0;
                    s_ready_d     = 1'b1;
                    timeout_err_d = 1'b1;
                    if (!op_q.wr) begin
                        s_readdata_d = REG_TIMEOUT_DATA;
                    end
                    state_d = DONE;
                end
            end

            // Upstream still holds its request during the s_ready cycle
            DONE: begin
                state_d = IDLE;
            end

            default: begin
                m_rd_d  = '0;
                m_wr_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (rst) begin
            state_q       <= IDLE;
            op_q          <= '0;
            m_addr_q      <= '0;
            m_writedata_q <= '0;
            m_rd_q        <= '0;
            m_wr_q        <= '0;
            s_ready_q     <= 1'b0;
            s_readdata_q  <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            m_addr_q      <= m_addr_d;
            m_writedata_q <= m_writedata_d;
            m_rd_q        <= m_rd_d;
            m_wr_q        <= m_wr_d;
            s_ready_q     <= s_ready_d;
            s_readdata_q  <= s_readdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign s_readdata  = s_readdata_q;
    assign m_addr      = m_addr_q;
    assign m_rd        = m_rd_q;
    assign m_wr        = m_wr_q;
    assign m_writedata = m_writedata_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/reg_addr_dec.md
Name: reg_addr_dec

Overview:
- Register-bus address decoder and timeout watchdog in the slow clock domain (clk_2).
- Consumes the slow-side register master bus produced by the fast-to-slow rate decoupler.
- Routes each rd/wr to one of 4 peripheral regions selected by the top two address bits.
- Muxes ready/readdata back to the requester; a peripheral that never answers cannot hang the bus.

Parameters:
- AW, 10, upstream address width; region select = s_addr[AW-1:AW-2], peripheral address = s_addr[AW-3:0].
- TO_CYC, 255, timeout in clk_2 cycles from strobe assertion to forced completion; legal range 1..65535.

Ports:
- clk_2  in  1  slow register-bus clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high, sampled on clk_2.
- s_addr  in  AW  request address from upstream master.
- s_rd  in  1  read request; upstream holds it high until it sees s_ready.
- s_wr  in  1  write request; same hold rule as s_rd.
- s_writedata  in  32  write data; valid while s_wr is high.
- s_ready  out  1  one-cycle completion pulse.
- s_readdata  out  32  read data; valid in the s_ready cycle of a read.
- m_addr  out  AW-2  peripheral address, common to all regions.
- m_rd  out  4  per-region read strobe, one-hot or zero.
- m_wr  out  4  per-region write strobe, one-hot or zero.
- m_writedata  out  32  write data, common to all regions.
- m_ready  in  4  per-region ready.
- m_readdata  in  128  per-region read data; region i occupies bits [32i+31:32i].
- timeout_err  out  1  one-cycle pulse when a transaction times out.
- err_cnt  out  16  saturating timeout count.

Behaviour:
- Reset values: s_ready=0, s_readdata=0, m_rd=0, m_wr=0, m_addr=0, m_writedata=0, timeout_err=0, err_cnt=0, FSM=IDLE, timeout counter=0.
- Reset asserted mid-transaction: all strobes drop on the next edge; no s_ready is issued.
- FSM has three states: IDLE, REQ, DONE.
- IDLE, s_rd|s_wr sampled high:
  - Latch region sel, m_addr, m_writedata and the operation type.
  - If s_rd and s_wr are both high, the transaction is a write.
  - Clear the timeout counter and go to REQ.
  - m_rd[sel] or m_wr[sel] goes high in the next cycle.
- REQ, m_ready[sel]=1:
  - Next cycle: s_ready=1 and the strobe drops.
  - For reads, s_readdata = m_readdata[sel] captured at that edge; writes leave s_readdata unchanged.
  - Go to DONE.
- REQ, no ready: increment the timeout counter each cycle.
- REQ, counter reaches TO_CYC-1 with no ready:
  - Next cycle: s_ready=1, timeout_err=1, strobe dropped.
  - For reads, s_readdata = 32'hDEADBEEF.
  - err_cnt increments, saturating at 16'hFFFF. Go to DONE.
- If ready arrives in the same cycle the timeout fires, ready wins: normal completion, no error.
- m_ready on non-selected regions is ignored at all times.
- DONE lasts one cycle and ignores s_rd/s_wr, because upstream still holds the request during the s_ready cycle. Then return to IDLE.
- Minimum round trip: request sampled at cycle 0, strobe high at cycle 1, ready at cycle 1, s_ready at cycle 2, IDLE at cycle 3, next request accepted at cycle 3.
- s_addr and s_writedata may change after acceptance without effect; values stay latched.
- No output depends combinationally on any input; all outputs are registered.

Decomposition:
- Shared package reg_bus_pkg holds:
  - REG_NREGION=4 and REG_SEL_W=2.
  - REG_TIMEOUT_DATA=32'hDEADBEEF.
  - The state enum {IDLE, REQ, DONE}.
  - The readdata slice helper for region i.
- The rate decoupler and later peripherals reuse this package.
- One natural sub-module: reg_to_wdog, containing the timeout counter plus saturating err_cnt; inputs start/run/hit, outputs expire/err_cnt.

Test Plan:
- Read region 2, addr 10'h2A5 (sel=2, m_addr=8'hA5); m_ready[2] 3 cycles after m_rd[2], data 32'h1234_5678 -> m_rd=4'b0100 exactly 3 cycles; one s_ready pulse; s_readdata=32'h1234_5678; timeout_err=0.
- Write region 0, addr 10'h013, data 32'hCAFE_0001; m_ready[0] 1 cycle after strobe -> m_wr=4'b0001 for 1 cycle; m_writedata=32'hCAFE_0001; m_addr=8'h13; s_ready 1 pulse; s_readdata unchanged.
- Read region 3 with TO_CYC=8 and m_ready held 0 -> m_rd[3] high 8 cycles; s_ready and timeout_err pulse together; s_readdata=32'hDEADBEEF; err_cnt=1.
- During a region-1 read, pulse m_ready[0] and m_ready[3] before m_ready[1] -> completion only on m_ready[1]; s_readdata = region 1 data.
- s_rd and s_wr both high -> write strobe only; upstream holding s_rd through the s_ready cycle -> exactly one transaction; next starts 1 cycle after DONE.
- Assert rst while m_wr[1] is high -> all strobes 0 next cycle; no s_ready; err_cnt=0.
- Force err_cnt to 16'hFFFF, then time out -> err_cnt stays 16'hFFFF.
